// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: three-channel PWM for the board RGB LED. Duty writes are staged and moved to shadow registers together at the period wrap. An optional fade sequencer drives a triangle ramp.
// Latency: a register write is visible the next clk; led_* lag pwm_cnt by one clk; disabling forces led_* low on the same edge the ctrl write lands.
// Backpressure: none. wr_en is accepted every cycle.
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data register write
//   (addr 0..2 = duty r/g/b, addr 3 = ctrl with bit0 enable and bit1 fade);
//   led_r/led_g/led_b active-high PWM; period_done one-clk pulse after each
//   wrap; fade_level current fade sequencer level.
module rgb_pwm_ctrl #(
  parameter int PWM_BITS   = 8,
  parameter int PRESC_DIV  = 64,
  parameter int PRESC_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                period_done,
  output logic [PWM_BITS-1:0] fade_level
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_FADE_UP, S_FADE_DOWN} state_t;

  localparam logic [PWM_BITS-1:0]   CNT_MAX    = '1;
  localparam logic [PWM_BITS-1:0]   CNT_PRE    = CNT_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0]   LVL_ZERO   = '0;
  localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(PRESC_DIV - 1);

  state_t                    state, state_nxt;
  logic [PWM_BITS-1:0]       fade_nxt;
  logic [2:0][PWM_BITS-1:0]  duty_stg;
  logic [2:0][PWM_BITS-1:0]  duty_sh;
  logic [2:0][PWM_BITS-1:0]  eff_duty;
  logic                      ctrl_en;
  logic                      ctrl_fade;
  logic [PRESC_BITS-1:0]     presc;
  logic [PWM_BITS-1:0]       pwm_cnt;

  logic ctrl_wr;
  logic en_nxt;
  logic active;
  logic counting;
  logic tick;
  logic wrap;
  logic load_sh;

  // The enable value that will be live after this edge. The LEDs use it, so a
  // disable write turns them off on the very edge it lands.
  assign ctrl_wr  = wr_en && (wr_addr == 2'd3);
  assign en_nxt   = ctrl_wr ? wr_data[0] : ctrl_en;
  assign active   = (state != S_OFF);
  // Counters run only once the FSM has left OFF, which lets the shadow load
  // on the exit from OFF before the first counted tick.
  assign counting = active && ctrl_en;
  assign tick     = counting && (presc == PRESC_LAST);
  assign wrap     = tick && (pwm_cnt == CNT_MAX);
  assign load_sh  = wrap || ((state == S_OFF) && ctrl_en);

  // A channel with zero shadow duty stays dark while fading.
  always_comb begin
    eff_duty = '0;
    for (int i = 0; i < 3; i++) begin
      if (ctrl_fade) begin
        eff_duty[i] = (duty_sh[i] != LVL_ZERO) ? fade_level : LVL_ZERO;
      end else begin
        eff_duty[i] = duty_sh[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      fade_level <= '0;
    end else begin
      state      <= state_nxt;
      fade_level <= fade_nxt;
    end
  end

  // The fade level steps only on a wrap. The direction flips on the same wrap
  // that reaches an end, so each end value is held for exactly one period.
  always_comb begin
    state_nxt = state;
    fade_nxt  = fade_level;
    if (!ctrl_en) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF: state_nxt = ctrl_fade ? S_FADE_UP : S_RUN;
        S_RUN: if (ctrl_fade) state_nxt = S_FADE_UP;
        S_FADE_UP: begin
          if (!ctrl_fade) begin
            state_nxt = S_RUN;
          end else if (wrap) begin
            if (fade_level == CNT_MAX) begin
              fade_nxt  = fade_level - 1'b1;
              state_nxt = S_FADE_DOWN;
            end else begin
              fade_nxt = fade_level + 1'b1;
              if (fade_level == CNT_PRE) state_nxt = S_FADE_DOWN;
            end
          end
        end
        S_FADE_DOWN: begin
          if (!ctrl_fade) begin
            state_nxt = S_RUN;
          end else if (wrap) begin
            if (fade_level == LVL_ZERO) begin
              fade_nxt  = fade_level + 1'b1;
              state_nxt = S_FADE_UP;
            end else begin
              fade_nxt = fade_level - 1'b1;
              if (fade_level == PWM_BITS'(1)) state_nxt = S_FADE_UP;
            end
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_stg    <= '0;
      duty_sh     <= '0;
      ctrl_en     <= 1'b0;
      ctrl_fade   <= 1'b0;
      presc       <= '0;
      pwm_cnt     <= '0;
      period_done <= 1'b0;
      led_r       <= 1'b0;
      led_g       <= 1'b0;
      led_b       <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          2'd0: duty_stg[0] <= wr_data;
          2'd1: duty_stg[1] <= wr_data;
          2'd2: duty_stg[2] <= wr_data;
          default: begin
            ctrl_en   <= wr_data[0];
            ctrl_fade <= wr_data[1];
          end
        endcase
      end

      // Shadow reads the staging value from before this edge. A write that
      // coincides with a wrap therefore waits for the following wrap.
      if (load_sh) duty_sh <= duty_stg;

      if (!counting) begin
        presc   <= '0;
        pwm_cnt <= '0;
      end else if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        presc   <= presc + 1'b1;
      end

      period_done <= wrap;
      led_r       <= active && en_nxt && (pwm_cnt < eff_duty[0]);
      led_g       <= active && en_nxt && (pwm_cnt < eff_duty[1]);
      led_b       <= active && en_nxt && (pwm_cnt < eff_duty[2]);
    end
  end

endmodule
